booth_multiplier_4bit: RTL
==========================

# booth_multiplier_4bit

Sequential radix-2 Booth multiplier for 4-bit two's-complement operands, producing an 8-bit signed product in four iteration cycles. It sits directly downstream of the operand source and drives the existing 4-bit `SubOrAdd` add/subtract stage once per iteration. It is the first clocked consumer of that stage. A start/busy/done handshake frames each operation.

## Interface
- Parameters: none. Width is fixed at 4 by the `SubOrAdd` stage.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `multiplicand`  in  4  signed M; captured on the accepting edge.
- `multiplier`  in  4  signed Q; captured on the accepting edge.
- `busy`  out  1  high while in CALC.
- `done`  out  1  one-cycle pulse; high while in DONE.
- `product`  out  8  signed M×Q; registered and held until the next completion.

## Operation
- Internal registers:
  - A[3:0], the accumulator.
  - Mr[3:0], the latched multiplicand.
  - Qr[3:0], the multiplier/low product.
  - q1, the Booth extra bit.
  - cnt[1:0], the iteration count.
  - state.
- States:
  - IDLE: if start is high, load Mr and Qr, clear A, q1 and cnt, then go to CALC.
  - CALC: perform one iteration per cycle. When cnt==3, go to DONE and load `product` <= {A',Qr'}, the post-shift values.
  - DONE: if start is high, reload as in IDLE and go to CALC. Otherwise go to IDLE.
- Each iteration inspects {Qr[0], q1}:
  - 01: add, A+Mr, with sub=0.
  - 10: subtract, A−Mr, with sub=1.
  - 00 or 11: pass A through.
- Add/sub stage hookup: a=A, b=Mr, Cin tied 0, sub as selected. Use its S and Cout.
- Sign extension: the true 5th result bit is e = A[3] ^ Mr[3] ^ sub ^ Cout. This makes M=−8 correct. When passing A through, e = A[3].
- Arithmetic right shift of {e, S, Qr, q1} by one:
  - A <= {e, S[3:1]}
  - Qr <= {S[0], Qr[3:1]}
  - q1 <= Qr[0]
- start is ignored while in CALC; no queuing, no error flag.
- Operand inputs are don't-care except on the accepting edge.

## Timing
- Reset asynchronously forces:
  - state=IDLE.
  - A, Mr, Qr, q1 and cnt all zero.
  - product=0x00, busy=0, done=0.
- Reset mid-operation aborts the operation; no done is produced.
- Latency, with start high before edge E0:
  - Edge E0 accepts the request.
  - Edges E1–E4 perform iterations 0–3.
  - done is high for exactly the cycle between E4 and E5.
  - product is valid from E4 onward.
- busy is high for E0→E4 (4 cycles). busy and done are never high together.
- Throughput: start held high in DONE is accepted at E5, giving one result every 5 cycles. Otherwise the block passes through one IDLE cycle.
- product changes only on the CALC→DONE edge and on reset.

## Structure
- A shared package/header holds:
  - state encodings: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - localparam LAST_ITER=2'd3.
- One sub-module instance: the existing `SubOrAdd`, instantiated as the datapath adder/subtractor.
- The shift, FSM and counter stay in this block.
- Unused state encoding 2'd3 recovers to IDLE.

## Test plan
- 3×5: start with M=4'h3, Q=4'h5 → done exactly 4 edges after acceptance, product=8'h0F.
- −8×−8: M=4'h8, Q=4'h8 → product=8'h40 (exercises the e-bit rule).
- −8×7 and 7×−1: M=4'h8, Q=4'h7 → product=8'hC8; M=4'h7, Q=4'hF → product=8'hF9.
- Start pulsed during CALC with different operands → ignored. First result completes unchanged; no extra done.
- start held high across DONE with M=2, Q=−3 following 3×5 → second operation accepted at E5. done pulses 5 cycles apart; product goes 8'h0F then 8'hFA.
- rst asserted at iteration 2 → busy, done and product are 0 immediately (asynchronously). A fresh start afterwards yields the correct product.

Source files
------------

// File: rtl/booth_multiplier_4bit_pkg.sv
// Shared definitions for the 4-bit sequential Booth multiplier.
// Holds the controller state encoding and the index of the final iteration.
package booth_multiplier_4bit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration index on which the last shift is applied and the result latched.
    localparam logic [1:0] LAST_ITER = 2'd3;

endpackage

// File: rtl/booth_multiplier_4bit_suboradd.sv
// SubOrAdd: 4-bit adder/subtractor stage used once per Booth iteration.
// Ports:
//   a, b  - 4-bit operands
//   Cin   - carry in (combined with sub to form the +1 of two's-complement subtract)
//   sub   - 0: S = a + b + Cin, 1: S = a - b (a + ~b + 1, with Cin = 0)
//   S     - 4-bit result
//   Cout  - carry out of bit 3
module SubOrAdd (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       Cin,
    input  logic       sub,
    output logic [3:0] S,
    output logic       Cout
);

    logic [3:0] b_eff;
    logic [4:0] sum;

    assign b_eff = b ^ {4{sub}};
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {4'b0000, Cin ^ sub};
    assign S     = sum[3:0];
    assign Cout  = sum[4];

endmodule

// File: rtl/booth_multiplier_4bit.sv
// booth_multiplier_4bit: sequential radix-2 Booth multiplier, 4-bit signed
// operands, 8-bit signed product, four iterations per operation.
// Ports:
//   clk          - rising-edge clock
//   rst          - asynchronous active-high reset
//   start        - request, honoured only in IDLE or DONE
//   multiplicand - signed M, captured on the accepting edge
//   multiplier   - signed Q, captured on the accepting edge
//   busy         - high while iterating
//   done         - one-cycle completion pulse
//   product      - registered signed M*Q, held until the next completion
module booth_multiplier_4bit
    import booth_multiplier_4bit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] multiplicand,
    input  logic [3:0] multiplier,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);

    state_t     state_q;
    logic [3:0] a_q;
    logic [3:0] mr_q;
    logic [3:0] qr_q;
    logic       q1_q;
    logic [1:0] cnt_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] product_q;

    // Post-shift values of one Booth iteration.
    logic [3:0] a_d;
    logic [3:0] qr_d;
    logic       q1_d;

    logic       sub;
    logic       use_sum;
    logic       e;
    logic [3:0] shift_src;
    logic [3:0] s;
    logic       cout;

    SubOrAdd u_suboradd (
        .a    (a_q),
        .b    (mr_q),
        .Cin  (1'b0),
        .sub  (sub),
        .S    (s),
        .Cout (cout)
    );

    always_comb begin
        sub     = 1'b0;
        use_sum = 1'b0;
        case ({qr_q[0], q1_q})
            2'b01: use_sum = 1'b1;
            2'b10: begin
                use_sum = 1'b1;
                sub     = 1'b1;
            end
            default: use_sum = 1'b0;
        endcase

        // e is the true 5th bit of the signed add/sub; it keeps M = -8 exact
        // where the 4-bit S alone would overflow.
        if (use_sum) begin
            e         = a_q[3] ^ mr_q[3] ^ sub ^ cout;
            shift_src = s;
        end else begin
            e         = a_q[3];
            shift_src = a_q;
        end

        a_d  = {e, shift_src[3:1]};
        qr_d = {shift_src[0], qr_q[3:1]};
        q1_d = qr_q[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= 4'h0;
            mr_q      <= 4'h0;
            qr_q      <= 4'h0;
            q1_q      <= 1'b0;
            cnt_q     <= 2'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= 8'h00;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= 4'h0;
                        mr_q    <= multiplicand;
                        qr_q    <= multiplier;
                        q1_q    <= 1'b0;
                        cnt_q   <= 2'd0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    a_q   <= a_d;
                    qr_q  <= qr_d;
                    q1_q  <= q1_d;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == LAST_ITER) begin
                        product_q <= {a_d, qr_d};
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
